// File: rtl/mips_ctrl_pkg.sv
// Shared control definitions for the MIPS pipeline sequencer.
//   div_state_e : divide sequencer state encoding
//   STALL_*     : per-stage hold vectors, bit order {wb,mem,ex,id,if,pc}
package mips_ctrl_pkg;

  typedef enum logic [1:0] {
    DivIdle = 2'd0,
    DivInit = 2'd1,
    DivRun  = 2'd2,
    DivDone = 2'd3
  } div_state_e;

  localparam int unsigned STALL_W = 6;

  localparam logic [STALL_W-1:0] STALL_NONE = 6'b000000;
  localparam logic [STALL_W-1:0] STALL_IFW  = 6'b000011;
  localparam logic [STALL_W-1:0] STALL_LU   = 6'b000111;
  localparam logic [STALL_W-1:0] STALL_DIV  = 6'b001111;
  localparam logic [STALL_W-1:0] STALL_MEM  = 6'b011111;

endpackage

// File: rtl/div_seq_fsm.sv
// Divider run/done sequencer with iteration counter.
// Ports:
//   clk, rst        : clock, asynchronous active-high reset
//   exc_flush       : kill in-flight divide, return to idle next cycle
//   div_start       : EX holds a div/divu (only sampled in idle)
//   ex_advance      : EX register advances this cycle (releases done)
//   div_init        : load-operands strobe (one cycle)
//   div_run         : divider step enable
//   div_done        : quotient/remainder valid in EX
//   div_busy        : init or run in progress (pipeline must hold)
module div_seq_fsm
  import mips_ctrl_pkg::*;
#(
  parameter int unsigned DIV_CYCLES = 32,
  parameter int unsigned CNT_W      = 6
) (
  input  logic clk,
  input  logic rst,
  input  logic exc_flush,
  input  logic div_start,
  input  logic ex_advance,
  output logic div_init,
  output logic div_run,
  output logic div_done,
  output logic div_busy
);

  localparam logic [CNT_W-1:0] CntLoad = CNT_W'(DIV_CYCLES - 1);

  div_state_e       state_q;
  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= DivIdle;
      cnt_q   <= '0;
    end else if (exc_flush) begin
      state_q <= DivIdle;
      cnt_q   <= '0;
    end else begin
      unique case (state_q)
        DivIdle: if (div_start) state_q <= DivInit;
        DivInit: begin
          state_q <= DivRun;
          cnt_q   <= CntLoad;
        end
        DivRun: begin
          // Keeps stepping regardless of downstream holds; never wraps.
          if (cnt_q == '0) state_q <= DivDone;
          else             cnt_q   <= cnt_q - CNT_W'(1);
        end
        // Stay done while EX is held so the held div is not restarted.
        DivDone: if (ex_advance) state_q <= DivIdle;
        default: state_q <= DivIdle;
      endcase
    end
  end

  // Strobes drop in the same cycle an exception commits.
  assign div_init = (state_q == DivInit) & ~exc_flush;
  assign div_run  = (state_q == DivRun)  & ~exc_flush;
  assign div_done = (state_q == DivDone) & ~exc_flush;
  assign div_busy = (state_q == DivInit) | (state_q == DivRun);

endmodule

// File: rtl/stall_flush_ctrl.sv
// Central pipeline sequencer for the 5-stage MIPS core. Merges fetch wait,
// data-memory wait, multi-cycle divide, load-use hazard and exception flush
// into one per-stage stall vector and one flush strobe.
// Ports:
//   clk, rst                 : clock, asynchronous active-high reset
//   exc_flush                : exception/ERET commit in MEM
//   inst_req, inst_ready     : fetch handshake
//   mem_req, mem_ready       : data-memory handshake
//   id_rs, id_rt, id_uses_rt : ID source operands
//   ex_memread, ex_rt        : EX load and its destination
//   ex_div_start             : EX holds a div/divu
//   stall[5:0]               : {wb,mem,ex,id,if,pc} hold enables
//   flush                    : clear IF/ID, ID/EX, EX/MEM
//   div_run/div_init/div_done: divider datapath controls
// Optional (macro STALL_FLUSH_CTRL_PERF_EN):
//   perf_stall_cycles[31:0]  : cycles with IF held (saturating)
//   perf_flush_cnt[15:0]     : flush cycles (saturating)
module stall_flush_ctrl
  import mips_ctrl_pkg::*;
#(
  parameter int unsigned DIV_CYCLES = 32,
  parameter int unsigned CNT_W      = 6
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         exc_flush,
  input  logic         inst_req,
  input  logic         inst_ready,
  input  logic         mem_req,
  input  logic         mem_ready,
  input  logic [4:0]   id_rs,
  input  logic [4:0]   id_rt,
  input  logic         id_uses_rt,
  input  logic         ex_memread,
  input  logic [4:0]   ex_rt,
  input  logic         ex_div_start,
`ifdef STALL_FLUSH_CTRL_PERF_EN
  output logic [31:0]  perf_stall_cycles,
  output logic [15:0]  perf_flush_cnt,
`endif
  output logic [5:0]   stall,
  output logic         flush,
  output logic         div_run,
  output logic         div_init,
  output logic         div_done
);

  logic div_busy;
  logic load_use;
  logic mem_wait;
  logic if_wait;

  assign mem_wait = mem_req & ~mem_ready;
  assign if_wait  = inst_req & ~inst_ready;
  // $zero never creates a hazard.
  assign load_use = ex_memread & (ex_rt != 5'd0) &
                    ((ex_rt == id_rs) | (id_uses_rt & (ex_rt == id_rt)));

  div_seq_fsm #(
    .DIV_CYCLES (DIV_CYCLES),
    .CNT_W      (CNT_W)
  ) u_div_seq (
    .clk        (clk),
    .rst        (rst),
    .exc_flush  (exc_flush),
    .div_start  (ex_div_start),
    .ex_advance (~stall[3]),
    .div_init   (div_init),
    .div_run    (div_run),
    .div_done   (div_done),
    .div_busy   (div_busy)
  );

  always_comb begin
    stall = STALL_NONE;
    flush = 1'b0;
    if (exc_flush)     flush = 1'b1;
    else if (mem_wait) stall = STALL_MEM;
    else if (div_busy) stall = STALL_DIV;
    else if (load_use) stall = STALL_LU;
    else if (if_wait)  stall = STALL_IFW;
  end

`ifdef STALL_FLUSH_CTRL_PERF_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_stall_cycles <= '0;
      perf_flush_cnt    <= '0;
    end else begin
      if (stall[1] && (perf_stall_cycles != '1)) perf_stall_cycles <= perf_stall_cycles + 32'd1;
      if (flush && (perf_flush_cnt != '1))       perf_flush_cnt    <= perf_flush_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_stall_flush_ctrl.sv
// Directed bench for stall_flush_ctrl (DIV_CYCLES=32).
module tb_stall_flush_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       exc_flush, inst_req, inst_ready, mem_req, mem_ready;
  logic [4:0] id_rs, id_rt, ex_rt;
  logic       id_uses_rt, ex_memread, ex_div_start;
  logic [5:0] stall;
  logic       flush, div_run, div_init, div_done;
`ifdef STALL_FLUSH_CTRL_PERF_EN
  logic [31:0] perf_stall_cycles;
  logic [15:0] perf_flush_cnt;
`endif

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  stall_flush_ctrl #(
    .DIV_CYCLES (32),
    .CNT_W      (6)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .exc_flush    (exc_flush),
    .inst_req     (inst_req),
    .inst_ready   (inst_ready),
    .mem_req      (mem_req),
    .mem_ready    (mem_ready),
    .id_rs        (id_rs),
    .id_rt        (id_rt),
    .id_uses_rt   (id_uses_rt),
    .ex_memread   (ex_memread),
    .ex_rt        (ex_rt),
    .ex_div_start (ex_div_start),
`ifdef STALL_FLUSH_CTRL_PERF_EN
    .perf_stall_cycles (perf_stall_cycles),
    .perf_flush_cnt    (perf_flush_cnt),
`endif
    .stall        (stall),
    .flush        (flush),
    .div_run      (div_run),
    .div_init     (div_init),
    .div_done     (div_done)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Pack all DIV strobes {init,run,done} for compact checks.
  function automatic logic [31:0] dv();
    return {29'd0, div_init, div_run, div_done};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    exc_flush = 0; inst_req = 0; inst_ready = 0; mem_req = 0; mem_ready = 0;
    id_rs = 0; id_rt = 0; id_uses_rt = 0; ex_memread = 0; ex_rt = 0; ex_div_start = 0;
    #12;
    chk("rst_stall", stall, 6'b000000);
    chk("rst_flush", flush, 0);
    chk("rst_div", dv(), 3'b000);
    rst = 1'b0;
    tick();

    // Load-use on rs, on rt, and the $zero exception.
    ex_memread = 1; ex_rt = 8; id_rs = 8; #1;
    chk("lu_rs", stall, 6'b000111);
    ex_rt = 0; id_rs = 0; #1;
    chk("lu_zero", stall, 6'b000000);
    ex_rt = 8; id_rs = 3; id_rt = 8; id_uses_rt = 1; #1;
    chk("lu_rt", stall, 6'b000111);
    id_uses_rt = 0; #1;
    chk("lu_rt_unused", stall, 6'b000000);
    ex_memread = 0; ex_rt = 0; id_rs = 0; id_rt = 0;

    // Fetch wait.
    inst_req = 1; inst_ready = 0; #1;
    chk("ifw", stall, 6'b000011);
    inst_ready = 1; #1;
    chk("ifw_ready", stall, 6'b000000);
    inst_req = 0; inst_ready = 0;

    // Full divide: 1 init + 32 run cycles stalled, then done, then idle.
    ex_div_start = 1; #1;
    chk("div_idle_stall", stall, 6'b000000);
    chk("div_idle_strb", dv(), 3'b000);
    tick();
    ex_div_start = 0; #1;
    chk("div_init_strb", dv(), 3'b100);
    chk("div_init_stall", stall, 6'b001111);
    for (int i = 0; i < 32; i++) begin
      tick();
      chk($sformatf("div_run%0d_strb", i), dv(), 3'b010);
      chk($sformatf("div_run%0d_stall", i), stall, 6'b001111);
    end
    tick();
    chk("div_done_strb", dv(), 3'b001);
    chk("div_done_stall", stall, 6'b000000);
    tick();
    chk("div_back_idle", dv(), 3'b000);

    // Mem wait overlapping DONE with ex_div_start still high.
    ex_div_start = 1;
    tick();
    chk("ov_init", dv(), 3'b100);
    for (int i = 0; i < 33; i++) tick();
    chk("ov_done", dv(), 3'b001);
    mem_req = 1; mem_ready = 0; #1;
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("ov_mem%0d_stall", i), stall, 6'b011111);
      chk($sformatf("ov_mem%0d_strb", i), dv(), 3'b001);
      tick();
    end
    mem_req = 0; ex_div_start = 0; #1;
    chk("ov_release_stall", stall, 6'b000000);
    chk("ov_release_strb", dv(), 3'b001);
    tick();
    chk("ov_idle_strb", dv(), 3'b000);
    chk("ov_idle_stall", stall, 6'b000000);

    // Exception during RUN at counter 10.
    ex_div_start = 1;
    tick();
    ex_div_start = 0;
    tick();  // RUN, counter 31
    for (int i = 0; i < 21; i++) tick();  // counter 10
    chk("exc_pre_run", dv(), 3'b010);
    exc_flush = 1; #1;
    chk("exc_flush", flush, 1);
    chk("exc_stall", stall, 6'b000000);
    chk("exc_strb", dv(), 3'b000);
    tick();
    exc_flush = 0; #1;
    chk("exc_after_strb", dv(), 3'b000);
    chk("exc_after_stall", stall, 6'b000000);
    chk("exc_after_flush", flush, 0);

    // Priority.
    exc_flush = 1; mem_req = 1; mem_ready = 0; ex_memread = 1; ex_rt = 5; id_rs = 5;
    inst_req = 1; #1;
    chk("pri_exc_stall", stall, 6'b000000);
    chk("pri_exc_flush", flush, 1);
    exc_flush = 0; #1;
    chk("pri_mem_stall", stall, 6'b011111);
    mem_req = 0; #1;
    chk("pri_lu_stall", stall, 6'b000111);
    ex_memread = 0; ex_rt = 0; id_rs = 0; inst_req = 0;

    // Mem stall during RUN does not stretch the divide.
    ex_div_start = 1;
    tick();
    ex_div_start = 0; mem_req = 1;
    for (int i = 0; i < 5; i++) tick();
    chk("mrun_stall", stall, 6'b011111);
    chk("mrun_strb", dv(), 3'b010);
    mem_req = 0;
    for (int i = 0; i < 28; i++) tick();
    chk("mrun_done", dv(), 3'b001);
    tick();

    // Asynchronous reset mid-RUN.
    ex_div_start = 1;
    tick();
    ex_div_start = 0;
    tick(); tick();
    chk("arst_pre_run", dv(), 3'b010);
    #1 rst = 1; #1;
    chk("arst_strb", dv(), 3'b000);
    chk("arst_stall", stall, 6'b000000);
`ifdef STALL_FLUSH_CTRL_PERF_EN
    chk("arst_perf_stall", perf_stall_cycles, 0);
    chk("arst_perf_flush", {16'd0, perf_flush_cnt}, 0);
`endif
    tick();
    rst = 0;
    tick();
    chk("post_rst_strb", dv(), 3'b000);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
